muldiv_sequencer: RTL and testbench

Multi-cycle signed multiply/divide unit for the pipelined MIPS core. It owns the HI/LO register pair and executes MULT and DIV iteratively, one bit per clock. It raises a pipeline stall whenever the pipeline tries to read HI/LO or issue a new MULT/DIV while an operation is in flight. It sits beside the execute-stage ALU and is driven by the same decoded hien/loen/funct information that selects MULT, DIV, MFHI and MFLO.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage <-> multiply/divide unit bundle.
//   start/op/srca/srcb : MULT/DIV issue and signed operands
//   hiread/loread      : MFHI/MFLO present in execute
//   busy/stall/done    : unit status, stall request, completion pulse
//   hi/lo              : architectural HI/LO registers
// master = pipeline side, slave = the multiply/divide unit.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hiread;
  logic             loread;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, hiread, loread,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, hiread, loread,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed MULT/DIV unit owning HI/LO.
// One bit per clock on operand magnitudes, sign fix-up in a final cycle.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any operation
//   bus   : slave side of muldiv_sequencer_if (issue, MFHI/MFLO, status, HI/LO)
// An op accepted on edge 0 keeps busy high for WIDTH+1 cycles; HI/LO and
// done appear together in cycle WIDTH+2.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               op_q;      // 0 = MULT, 1 = DIV
  logic               neg_q;     // product / quotient is negative
  logic               rneg_q;    // remainder follows dividend sign
  logic               dz_q;      // divisor was zero
  logic [WIDTH-1:0]   srca_q;    // raw dividend, becomes HI on divide by zero
  logic [2*WIDTH-1:0] acc;       // product accumulator
  logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;    // multiplier, consumed LSB first
  logic [WIDTH-1:0]   rem;       // settled remainder (always < divisor)
  logic [WIDTH-1:0]   quot;      // dividend bits leave at MSB, quotient bits enter at LSB
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Restoring divide step: the WIDTH+1-bit partial remainder minus the
  // divisor always lies in [-dvsr, dvsr-1], so its top bit is the borrow.
  logic [WIDTH:0] rem_sh, trial;
  assign rem_sh = {rem, quot[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  // Sign fix-up of the finished unsigned results.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;
  assign prod_s = neg_q  ? -acc  : acc;
  assign quot_s = neg_q  ? -quot : quot;
  assign rem_s  = rneg_q ? -rem  : rem;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      srca_q <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quot   <= '0;
      dvsr   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            neg_q  <= bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
            rneg_q <= bus.srca[WIDTH-1];
            dz_q   <= (bus.srcb == '0);
            srca_q <= bus.srca;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag(bus.srca)};
            mplier <= mag(bus.srcb);
            rem    <= '0;
            quot   <= mag(bus.srca);
            dvsr   <= mag(bus.srcb);
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!op_q) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
            rem  <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          end
        end
        SIGN: begin
          done_q <= 1'b1;
          if (!op_q) begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end else if (dz_q) begin
            // Divide by zero: no trap, fixed pattern, no sign correction.
            hi_q <= srca_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_s;
            lo_q <= quot_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.hiread | bus.loread);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random bench for muldiv_sequencer.
// A cycle-level reference (latency countdown + plain signed arithmetic) is
// compared against busy/stall/done/hi/lo every cycle; directed cases also
// pin latency and HI/LO to hand-computed literals.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Reference state: cycles left busy, pending result, visible HI/LO.
  int m_left = 0;
  logic m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_pend = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {hi, lo} from signed arithmetic: full product, or truncating quotient/remainder.
  function automatic logic [2*W-1:0] ref_result(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p = sa * sb;
      return p;
    end
    if (b == '0) return {a, {W{1'b1}}};
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_pend = ref_result(bus.op, bus.srca, bus.srcb);
        m_left = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  bus.busy,  W'(m_left > 0));
      chk("stall", bus.stall, W'((m_left > 0) && (bus.start || bus.hiread || bus.loread)));
      chk("done",  bus.done,  W'(m_done));
      chk("hi",    bus.hi,    m_hi);
      chk("lo",    bus.lo,    m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue in the current cycle, drop start after acceptance, expect done
  // exactly 34 cycles later with the given HI/LO.
  task automatic run_op(input string nm, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int k;
    bus.start = 1'b1; bus.op = o; bus.srca = a; bus.srcb = b;
    tick();
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 40) begin
      tick();
      k++;
    end
    chk({nm, "_lat"}, k, 34);
    chk({nm, "_hi"}, bus.hi, eh);
    chk({nm, "_lo"}, bus.lo, el);
  endtask

  initial begin
    int k;
    logic [W-1:0] a, b;
    bus.start = 1'b0; bus.op = 1'b0; bus.srca = '0; bus.srcb = '0;
    bus.hiread = 1'b0; bus.loread = 1'b0;
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    tick();

    run_op("mul_7xm3",  1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7d2",  1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7dm2",  1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run_op("div_5d0",   1'b1, 32'd5,          32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("div_mindm1",1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000);
    run_op("mul_minmin",1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'd0);

    // MFHI held from cycle 2, second DIV held from cycle 5.
    bus.start = 1'b1; bus.op = 1'b0; bus.srca = 32'd3; bus.srcb = 32'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.hiread = 1'b1;
    for (int c = 2; c <= 34; c++) begin
      if (c == 5) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.srca = 32'd100; bus.srcb = 32'd7;
      end
      #1;
      chk("stall_win", bus.stall, W'(c <= 33));
      if (c < 34) tick();
    end
    chk("hz_done1", bus.done, 1);
    chk("hz_lo1", bus.lo, 32'd15);
    tick();
    bus.start = 1'b0; bus.hiread = 1'b0;
    k = 35;
    while (!bus.done && k < 75) begin
      tick();
      k++;
    end
    chk("hz_done2_cyc", k, 68);
    chk("hz_lo2", bus.lo, 32'd14);
    chk("hz_hi2", bus.hi, 32'd2);
    tick();

    // Reset in cycle 10 of a MULT, new op from cycle 11.
    bus.start = 1'b1; bus.op = 1'b0; bus.srca = 32'h1234; bus.srcb = 32'h5678;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    run_op("post_abort", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    tick();

    // Back-to-back random sweep: start held, each op accepted in the done cycle.
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 19) == 0) ? 32'h80000000 : $urandom();
      b = ($urandom_range(0, 15) == 0) ? 32'd0 :
          ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFF : $urandom();
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      bus.start = 1'b1; bus.op = i[0]; bus.srca = a; bus.srcb = b;
      bus.loread = ($urandom_range(0, 3) == 0);
      repeat (34) tick();
    end
    bus.start = 1'b0; bus.loread = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
